// File: rtl/tbus_arbiter.sv
// Arbitrates one dcache tbus port between the load unit and the store queue.
// One operation is outstanding at a time; a flush cancels younger in-flight loads.
module tbus_arbiter #(
  parameter int ROB_SIZE_LOG = 6
) (
  input  logic                    clock,
  input  logic                    reset_n,

  input  logic                    load2arb_tbus_index_valid,
  output logic                    load2arb_tbus_index_ready,
  input  logic [63:0]             load2arb_tbus_index,
  input  logic [63:0]             load2arb_tbus_write_data,
  input  logic [63:0]             load2arb_tbus_write_mask,
  input  logic [1:0]              load2arb_tbus_operation_type,
  input  logic [ROB_SIZE_LOG:0]   load2arb_robid,
  output logic [63:0]             load2arb_tbus_read_data,
  output logic                    load2arb_tbus_operation_done,

  input  logic                    sq2arb_tbus_index_valid,
  output logic                    sq2arb_tbus_index_ready,
  input  logic [63:0]             sq2arb_tbus_index,
  input  logic [63:0]             sq2arb_tbus_write_data,
  input  logic [63:0]             sq2arb_tbus_write_mask,
  input  logic [1:0]              sq2arb_tbus_operation_type,
  output logic [63:0]             sq2arb_tbus_read_data,
  output logic                    sq2arb_tbus_operation_done,

  output logic                    tbus_index_valid,
  input  logic                    tbus_index_ready,
  output logic [63:0]             tbus_index,
  output logic [63:0]             tbus_write_data,
  output logic [63:0]             tbus_write_mask,
  output logic [1:0]              tbus_operation_type,
  input  logic [63:0]             tbus_read_data,
  input  logic                    tbus_operation_done,

  input  logic                    flush_valid,
  input  logic [ROB_SIZE_LOG:0]   flush_robid,
  output logic                    arb2dcache_flush_valid
);

  localparam int RW = ROB_SIZE_LOG + 1;

  typedef enum logic [1:0] {IDLE, LD_BUSY, SQ_BUSY, LD_DRAIN} state_t;

  state_t        state_q, state_d;
  logic          rr_last_q, rr_last_d;
  logic [RW-1:0] robid_q, robid_d;

  logic ld_elig, sq_elig, sel_ld, sel_sq, flush_hit, ld_fwd, sq_fwd;

  // Wrap flag inverts the sense of the index comparison
  function automatic logic is_younger(input logic [RW-1:0] f, input logic [RW-1:0] r);
    return (f[RW-1] ^ r[RW-1]) ^ (f[RW-2:0] < r[RW-2:0]);
  endfunction

  always_comb begin
    ld_elig = load2arb_tbus_index_valid & ~(flush_valid & is_younger(flush_robid, load2arb_robid));
    sq_elig = sq2arb_tbus_index_valid;
    sel_ld  = 1'b0;
    sel_sq  = 1'b0;
    if (state_q == IDLE) begin
      // rr_last_q high means the store queue was granted last, so the load unit takes a tie
      sel_ld = ld_elig & (~sq_elig | rr_last_q);
      sel_sq = sq_elig & ~sel_ld;
    end
    flush_hit = (state_q == LD_BUSY) & flush_valid & is_younger(flush_robid, robid_q);
    ld_fwd    = (state_q == LD_BUSY) & tbus_operation_done & ~flush_hit;
    sq_fwd    = (state_q == SQ_BUSY) & tbus_operation_done;
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    robid_d   = robid_q;
    case (state_q)
      IDLE: begin
        if (tbus_index_ready) begin
          if (sel_ld) begin
            state_d   = LD_BUSY;
            rr_last_d = 1'b0;
            robid_d   = load2arb_robid;
          end else if (sel_sq) begin
            state_d   = SQ_BUSY;
            rr_last_d = 1'b1;
          end
        end
      end
      LD_BUSY: begin
        if (flush_hit) begin
          state_d = tbus_operation_done ? IDLE : LD_DRAIN;
        end else if (tbus_operation_done) begin
          state_d = IDLE;
        end
      end
      SQ_BUSY, LD_DRAIN: begin
        if (tbus_operation_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, including the combinational IDLE paths
  always_comb begin
    tbus_index_valid             = 1'b0;
    tbus_index                   = '0;
    tbus_write_data              = '0;
    tbus_write_mask              = '0;
    tbus_operation_type          = '0;
    load2arb_tbus_index_ready    = 1'b0;
    load2arb_tbus_read_data      = '0;
    load2arb_tbus_operation_done = 1'b0;
    sq2arb_tbus_index_ready      = 1'b0;
    sq2arb_tbus_read_data        = '0;
    sq2arb_tbus_operation_done   = 1'b0;
    arb2dcache_flush_valid       = 1'b0;
    if (reset_n) begin
      tbus_index_valid = sel_ld | sel_sq;
      if (sel_ld) begin
        tbus_index          = load2arb_tbus_index;
        tbus_write_data     = load2arb_tbus_write_data;
        tbus_write_mask     = load2arb_tbus_write_mask;
        tbus_operation_type = load2arb_tbus_operation_type;
      end else if (sel_sq) begin
        tbus_index          = sq2arb_tbus_index;
        tbus_write_data     = sq2arb_tbus_write_data;
        tbus_write_mask     = sq2arb_tbus_write_mask;
        tbus_operation_type = sq2arb_tbus_operation_type;
      end
      load2arb_tbus_index_ready    = sel_ld & tbus_index_ready;
      sq2arb_tbus_index_ready      = sel_sq & tbus_index_ready;
      load2arb_tbus_operation_done = ld_fwd;
      load2arb_tbus_read_data      = ld_fwd ? tbus_read_data : '0;
      sq2arb_tbus_operation_done   = sq_fwd;
      sq2arb_tbus_read_data        = sq_fwd ? tbus_read_data : '0;
      arb2dcache_flush_valid       = flush_hit;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b0;
      robid_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      robid_q   <= robid_d;
    end
  end

endmodule

// File: doc/tbus_arbiter.md
TBUS_ARBITER -- requirements
Module: tbus_arbiter

Interface
REQ-001 Parameter ROB_SIZE_LOG, 6, ROB index width; every robid is ROB_SIZE_LOG+1 bits, the MSB being the wrap flag.
REQ-002 clock  in  1  single clock, rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 load2arb_tbus_index_valid / _index_ready  in / out  1 / 1  load-unit request handshake.
REQ-005 load2arb_tbus_index, _write_data, _write_mask  in  64 each  load-unit address, data and byte mask.
REQ-006 load2arb_tbus_operation_type  in  2  load-unit op type.
REQ-007 load2arb_robid  in  ROB_SIZE_LOG+1  robid of the load request.
REQ-008 load2arb_tbus_read_data / _operation_done  out  64 / 1  load-unit response.
REQ-009 sq2arb_tbus_* (index_valid, index_ready, index, write_data, write_mask, operation_type, read_data, operation_done)  same directions and widths as the load-unit channel, no robid  store-queue channel.
REQ-010 tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type  out  1/64/64/64/2  dcache request.
REQ-011 tbus_index_ready, tbus_read_data, tbus_operation_done  in  1/64/1  dcache handshake and response.
REQ-012 flush_valid / flush_robid  in  1 / ROB_SIZE_LOG+1  backend redirect.
REQ-013 arb2dcache_flush_valid  out  1  cancel pulse to the dcache.

Function
REQ-014 FSM states: IDLE, LD_BUSY, SQ_BUSY, LD_DRAIN; at most one dcache operation is outstanding.
REQ-015 IDLE grant selection is combinational: one valid requester wins; if both are valid, the requester not granted last wins (1-bit rr_last).
REQ-016 Flush-younger test: younger(r) = (flush_robid[MSB] ^ r[MSB]) ^ (flush_robid[MSB-1:0] < r[MSB-1:0]).
REQ-017 In IDLE, a load request with flush_valid and younger(load2arb_robid) is masked: it is not eligible and gets no index_ready.
REQ-018 In IDLE, tbus_index_valid = OR of the eligible valids; the tbus request fields are muxed from the winner.
REQ-019 Winner's index_ready = tbus_index_ready in IDLE; the loser's index_ready is 0; both index_ready are 0 in every other state.
REQ-020 On handshake (valid & ready in IDLE): go to LD_BUSY or SQ_BUSY, set rr_last to the winner, and capture the load robid when the load unit wins.
REQ-021 BUSY states: tbus_index_valid = 0; tbus_read_data drives the owner's read_data and tbus_operation_done drives the owner's operation_done; the non-owner sees 0.
REQ-022 BUSY → IDLE on the cycle after tbus_operation_done; a new grant is possible in that IDLE cycle (two-cycle minimum turnaround).
REQ-023 LD_BUSY with flush_valid and younger(captured robid): arb2dcache_flush_valid = 1 for exactly that cycle, go to LD_DRAIN, and do not forward operation_done in that cycle.
REQ-024 LD_DRAIN: wait for tbus_operation_done, swallow it (load operation_done stays 0), then return to IDLE; further flushes are ignored.
REQ-025 If flush and tbus_operation_done occur in the same LD_BUSY cycle, the flush wins: done is suppressed, the flush pulse is sent, and the FSM goes directly to IDLE.
REQ-026 SQ_BUSY is never flushed (committed stores); arb2dcache_flush_valid stays 0 in SQ_BUSY.
REQ-027 An older or equal robid, or a flush in IDLE/SQ_BUSY, has no effect beyond REQ-017.
REQ-028 The response read_data to a requester is 0 whenever its operation_done is 0.

Reset
REQ-029 Asynchronous assertion: state = IDLE, rr_last = load (store queue wins the first tie), captured robid = 0, arb2dcache_flush_valid = 0.
REQ-030 While reset_n = 0, all ready, done, valid and data outputs are 0; an in-flight operation is abandoned with no done forwarded.
REQ-031 After deassertion, the first grant is possible in the first clock.

Verification
REQ-032 Load only (index 0x80, type read), dcache ready, done after 3 cycles with 0xDEAD → load index_ready 1 in cycle 0; load done with 0xDEAD in cycle 3; sq sees nothing.
REQ-033 Both valid continuously from reset, each op done after 1 cycle → grants alternate SQ, LD, SQ, LD; no back-to-back grants to the same requester.
REQ-034 Load granted with robid 0x05; flush_robid 0x03 one cycle later → arb2dcache_flush_valid pulses once; later dcache done is swallowed; FSM back to IDLE.
REQ-035 Wrap case: load robid 0x41 (flag 1) in IDLE, flush_robid 0x3F (flag 0) same cycle → load not granted (younger); flush_robid 0x42 → load granted.
REQ-036 Flush and done in the same LD_BUSY cycle → no load done, one flush pulse, IDLE next cycle; sq request is granted the following cycle.
REQ-037 reset_n dropped mid SQ_BUSY → outputs 0 immediately; after release, a fresh SQ request is granted in the first cycle.
